fifo_trans: RTL and testbench

Synchronous show-ahead FIFO for the transaction layer, instantiated four times on the input side (feeding the arbiter's `empty_pN`/`data_inN`, driven by its `pop_pN`) and four times on the output side (written by the arbiter's `push_pN`/`data2send_cond`, reporting `almostfull_pN` back to it). It stores 10-bit words (`[9:8]` destination, `[7:0]` payload), with occupancy flags derived from a registered count. The head word is visible without a read cycle because the arbiter pops and samples data combinationally in the same cycle.

---
 rtl/fifo_trans.sv | 90 +++++++++
 tb/tb_fifo_trans.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_trans.sv
// fifo_trans: synchronous show-ahead FIFO for the transaction layer.
// The head word is always visible on data_out; flags decode the registered count.
// Optional build macro: FIFO_ERROR_EN adds a sticky overflow/underflow 'error' output.
module fifo_trans #(
  parameter int DATA_W          = 10,
  parameter int DEPTH           = 8,
  parameter int ALMOST_FULL_TH  = 6,
  parameter int ALMOST_EMPTY_TH = 2,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic [DATA_W-1:0] data_in,
  input  logic              pop,
  output logic [DATA_W-1:0] data_out,
  output logic              empty,
  output logic              full,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CW-1:0]     count
`ifdef FIFO_ERROR_EN
  ,
  output logic              error
`endif
);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CW-1:0]     r_count;
  logic              w_wr_en;
  logic              w_rd_en;

  // A write at full is only legal when a read frees the slot in the same edge.
  assign w_wr_en = push & (~full | pop);
  assign w_rd_en = pop & ~empty;

  // Flags come from the registered count only, never from push/pop.
  assign count        = r_count;
  assign empty        = (r_count == '0);
  assign full         = (r_count == CW'(DEPTH));
  assign almost_full  = (r_count >= CW'(ALMOST_FULL_TH));
  assign almost_empty = (r_count <= CW'(ALMOST_EMPTY_TH));
  assign data_out     = r_mem[r_rd_ptr];

  // Storage: cleared on reset so data_out reads 0 while empty after reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (w_wr_en) begin
      r_mem[r_wr_ptr] <= data_in;
    end
  end

  // Pointers wrap naturally; count moves only when exactly one side is accepted.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_wr_en, w_rd_en})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

`ifdef FIFO_ERROR_EN
  logic r_error;
  logic w_overflow;
  logic w_underflow;

  assign w_overflow  = push & full & ~pop;
  assign w_underflow = pop & empty;
  assign error       = r_error;

  // Sticky error: set by any dropped write or ignored read until reset.
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L)                       r_error <= 1'b0;
    else if (w_overflow || w_underflow) r_error <= 1'b1;
  end
`endif

endmodule

// File: tb/tb_fifo_trans.sv
// Testbench for fifo_trans (DEPTH=8, AF=6, AE=2); scoreboard queue holds expected words.
module tb_fifo_trans;
  localparam int DATA_W = 10;
  localparam int DEPTH  = 8;
  localparam int CW     = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset_L = 1'b1;
  logic              push = 1'b0;
  logic              pop = 1'b0;
  logic [DATA_W-1:0] data_in = '0;
  logic [DATA_W-1:0] data_out;
  logic              empty, full, almost_full, almost_empty;
  logic [CW-1:0]     count;
`ifdef FIFO_ERROR_EN
  logic              error;
`endif

  int errors = 0;
  int checks = 0;
  logic [DATA_W-1:0] sb[$];
  bit m_err = 1'b0;

  fifo_trans #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ALMOST_FULL_TH(6), .ALMOST_EMPTY_TH(2)) dut (
    .clk(clk), .reset_L(reset_L), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .empty(empty), .full(full), .almost_full(almost_full),
    .almost_empty(almost_empty), .count(count)
`ifdef FIFO_ERROR_EN
    , .error(error)
`endif
  );

  always #5 clk = ~clk;

  // One cycle of stimulus: drive at negedge, compare popped head against the
  // scoreboard, update the model, then check count/flags #1 after the edge.
  task automatic step(input bit p, input logic [DATA_W-1:0] d, input bit q);
    bit wr, rd;
    @(negedge clk);
    push = p; data_in = d; pop = q;
    #1;
    rd = q && (sb.size() > 0);
    wr = p && ((sb.size() < DEPTH) || q);
    if ((p && !wr) || (q && sb.size() == 0)) m_err = 1'b1;
    checks++;
    if (rd) begin
      logic [DATA_W-1:0] exp_w;
      exp_w = sb.pop_front();
      if (data_out !== exp_w) begin
        errors++;
        $display("FAIL pop_data: got %h expected %h", data_out, exp_w);
      end
    end else if (empty !== (sb.size() == 0)) begin
      errors++;
      $display("FAIL pre_empty: got %b expected %b", empty, sb.size() == 0);
    end
    if (wr) sb.push_back(d);
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0;
    checks++;
    if (count !== CW'(sb.size())) begin
      errors++;
      $display("FAIL count: got %0d expected %0d", count, sb.size());
    end
    checks++;
    if ({empty, full, almost_full, almost_empty} !==
        {sb.size() == 0, sb.size() == DEPTH, sb.size() >= 6, sb.size() <= 2}) begin
      errors++;
      $display("FAIL flags(e,f,af,ae): got %b%b%b%b at size %0d",
               empty, full, almost_full, almost_empty, sb.size());
    end
    if (sb.size() > 0) begin
      checks++;
      if (data_out !== sb[0]) begin
        errors++;
        $display("FAIL head: got %h expected %h", data_out, sb[0]);
      end
    end
`ifdef FIFO_ERROR_EN
    checks++;
    if (error !== m_err) begin
      errors++;
      $display("FAIL error_flag: got %b expected %b", error, m_err);
    end
`endif
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear without a clock edge.
  task automatic pulse_reset();
    @(negedge clk);
    #2 reset_L = 1'b0;
    #1;
    sb.delete();
    m_err = 1'b0;
    checks++;
    if ({empty, full, almost_full, almost_empty} !== 4'b1001 || count !== '0 || data_out !== '0) begin
      errors++;
      $display("FAIL reset_vals: e=%b f=%b af=%b ae=%b cnt=%0d dout=%h required 1,0,0,1,0,000",
               empty, full, almost_full, almost_empty, count, data_out);
    end
`ifdef FIFO_ERROR_EN
    checks++;
    if (error !== 1'b0) begin
      errors++;
      $display("FAIL reset_error: got %b expected 0", error);
    end
`endif
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  task automatic test_reset();
    pulse_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (empty !== 1'b1 || count !== '0 || data_out !== 10'h000) begin
      errors++;
      $display("FAIL idle_after_reset: e=%b cnt=%0d dout=%h", empty, count, data_out);
    end
  endtask

  task automatic test_order();
    step(1, 10'h101, 0);
    checks++;
    if (data_out !== 10'h101 || empty !== 1'b0) begin
      errors++;
      $display("FAIL first_word_latency: dout=%h e=%b expected 101,0", data_out, empty);
    end
    step(1, 10'h202, 0);
    step(1, 10'h303, 0);
    repeat (3) step(0, '0, 1);
    checks++;
    if (empty !== 1'b1 || count !== '0) begin
      errors++;
      $display("FAIL drain_empty: e=%b cnt=%0d expected 1,0", empty, count);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      step(1, DATA_W'(i), 0);
      checks++;
      if (almost_full !== (i >= 5) || full !== (i == DEPTH - 1)) begin
        errors++;
        $display("FAIL fill_flags push %0d: af=%b f=%b", i + 1, almost_full, full);
      end
    end
    step(1, 10'h3FF, 0);
    checks++;
    if (count !== CW'(8) || data_out !== 10'h000) begin
      errors++;
      $display("FAIL overflow_drop: cnt=%0d dout=%h expected 8,000", count, data_out);
    end
  endtask

  task automatic test_full_pushpop();
    step(1, 10'h2AA, 1);
    checks++;
    if (count !== CW'(8) || data_out !== 10'h001) begin
      errors++;
      $display("FAIL full_pushpop: cnt=%0d dout=%h expected 8,001", count, data_out);
    end
    for (int i = 0; i < DEPTH; i++) step(0, '0, 1);
    checks++;
    if (empty !== 1'b1) begin
      errors++;
      $display("FAIL full_drain_empty: got %b expected 1", empty);
    end
  endtask

  task automatic test_empty_pushpop();
    pulse_reset();
    step(1, 10'h155, 1);
    checks++;
    if (count !== CW'(1) || data_out !== 10'h155) begin
      errors++;
      $display("FAIL empty_pushpop: cnt=%0d dout=%h expected 1,155", count, data_out);
    end
    step(0, '0, 1);
    step(0, '0, 1);
    checks++;
    if (count !== '0 || empty !== 1'b1) begin
      errors++;
      $display("FAIL underflow_ignored: cnt=%0d e=%b expected 0,1", count, empty);
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 5; i++) step(1, DATA_W'(10'h040 + i), 0);
    pulse_reset();
    step(1, 10'h0F0, 0);
    checks++;
    if (count !== CW'(1) || data_out !== 10'h0F0) begin
      errors++;
      $display("FAIL after_reset_push: cnt=%0d dout=%h expected 1,0F0", count, data_out);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 40; i++)
      step(1'($urandom_range(0, 1)), DATA_W'($urandom), 1'($urandom_range(0, 1)));
    while (sb.size() > 0) step(0, '0, 1);
  endtask

  initial begin
    test_reset();
    test_order();
    test_full();
    test_full_pushpop();
    test_empty_pushpop();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
